apex7_watch_seq: RTL
====================

// Module: apex7_watch_seq
// PURPOSE
//  Clocked, parametrised successor of the apex7 watch/channel control logic.
//  Counts WATCH cycles (BULL counter) and checks one selected CAT channel per cycle.
//  Counts qualified channel faults (STAR counter) and reports MATCH/LIMIT events over a valid/ready port.
//  Keeps sticky status (MARSSR, LSD) and a per-channel PLUTO hit map; sits between the IBT/CAT front end and the supervisor.
// PARAMETERS
//  BULL_W     7   width of the WATCH cycle counter
//  BULL_MATCH 83  BULL value that raises a MATCH event (must fit in BULL_W)
//  STAR_W     4   width of the fault counter
//  STAR_MAX   15  fault count that raises a LIMIT event (1..2^STAR_W-1)
//  NCH        6   number of CAT channels / PLUTO bits
//  SEL_W      3   channel select width (2^SEL_W >= NCH)
// PORTS
//  CLK        in   1       single clock, rising edge
//  RST_N      in   1       asynchronous active-low reset
//  ICLR       in   1       synchronous clear of all state, incl. sticky bits
//  OWL_N      in   1       0 = quiesce: FSM->IDLE, counters->0, sticky/PLUTO kept
//  WATCH      in   1       watch-active strobe, sampled every cycle
//  FBI        in   1       fault qualifier
//  IBT        in   SEL_W   channel select
//  CAT        in   NCH     per-channel status, 0 = channel fault
//  RPT_READY  in   1       report sink ready
//  RPT_VALID  out  1       report valid
//  RPT_CODE   out  2       01 MATCH, 10 LIMIT, 00 none
//  RPT_CH     out  SEL_W   channel latched with report
//  BULL       out  BULL_W  WATCH counter
//  STAR       out  STAR_W  fault counter
//  PLUTO      out  NCH     sticky hit map, bit = channel reported
//  MARSSR     out  1       sticky: MATCH seen
//  LSD        out  1       sticky: LIMIT seen
//  VERR_F     out  1       1-cycle pulse: illegal select (IBT >= NCH) while RUN
//  END        out  1       1 while in HALT
// BEHAVIOUR
//  - All outputs registered. RST_N low: every output 0, FSM=IDLE, immediately and asynchronously.
//  - Priority each edge: RST_N > ICLR > OWL_N=0 > FSM.
//  - FSM states IDLE, RUN, REPORT, HALT (2-bit encoding).
//  - IDLE: WATCH=1 -> RUN with BULL<=BULL+1. WATCH=0: hold.
//  - RUN, WATCH=1: BULL<=BULL+1, wrapping all-ones->0 without any flag.
//  - RUN, WATCH=0: -> IDLE; BULL and STAR held.
//  - RUN: fault = WATCH & FBI & (IBT<NCH) & ~CAT[IBT]; on fault STAR<=STAR+1.
//  - RUN: IBT>=NCH with WATCH=1 -> VERR_F=1 next cycle only; no fault counted.
//  - MATCH = WATCH & (BULL+1 == BULL_MATCH); LIMIT = fault & (STAR+1 == STAR_MAX).
//  - MATCH or LIMIT in RUN -> REPORT next cycle with RPT_VALID=1; latency 1 cycle.
//  - Entering REPORT: RPT_CH<=IBT; MARSSR/LSD set for each event present.
//  - MATCH and LIMIT in the same cycle: RPT_CODE=10; both sticky bits set.
//  - REPORT: counters frozen; RPT_VALID/RPT_CODE/RPT_CH stable until RPT_VALID&RPT_READY.
//  - Transfer cycle: PLUTO[RPT_CH]<=1, RPT_VALID<=0.
//  - After transfer: MATCH -> IDLE, BULL<=0; LIMIT -> HALT.
//  - RPT_READY high on REPORT entry: transfer completes in that same cycle (1-cycle report).
//  - HALT: END=1; all inputs ignored except RST_N/ICLR.
//  - OWL_N=0 or ICLR in REPORT aborts the report: RPT_VALID=0 next cycle, PLUTO not updated.
//  - STAR saturation is impossible: LIMIT fires at STAR_MAX.
// TESTING
//  - Reset: RST_N low mid-RUN (BULL=5) -> all outputs 0 with no clock edge; FSM=IDLE.
//  - MATCH: WATCH=1 held, no faults -> RPT_VALID=1 after the edge where BULL becomes 83.
//    Then RPT_CODE=01, MARSSR=1; RPT_READY=1 -> IDLE, BULL=0.
//  - LIMIT: IBT=2, CAT[2]=0, FBI=WATCH=1 for 15 cycles -> RPT_CODE=10, RPT_CH=2, LSD=1.
//    RPT_READY=1 -> PLUTO=000100, END=1.
//  - Backpressure: RPT_READY=0 for 10 cycles in REPORT -> outputs stable, BULL/STAR frozen.
//    RPT_READY=1 -> transfer in one cycle.
//  - Simultaneous events: STAR=14 and BULL=82 with a fault cycle -> RPT_CODE=10, MARSSR=LSD=1.
//  - Illegal select/quiesce: IBT=7 with WATCH=1 -> one VERR_F pulse, STAR unchanged.
//    OWL_N=0 in REPORT -> RPT_VALID=0, PLUTO kept, counters 0.

Source files
------------

// File: rtl/apex7_watch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : apex7_watch_seq
//  Description : Clocked watch/channel controller. Counts WATCH cycles (bull),
//                counts qualified per-channel faults (star), and reports
//                MATCH/LIMIT events over a valid/ready port. Keeps sticky
//                event flags and a per-channel hit map (pluto).
//  Revision    : 1.0 - initial release
// ============================================================================
module apex7_watch_seq #(
    parameter int BULL_W     = 7,
    parameter int BULL_MATCH = 83,
    parameter int STAR_W     = 4,
    parameter int STAR_MAX   = 15,
    parameter int NCH        = 6,
    parameter int SEL_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iclr,
    input  logic              owl_n,
    input  logic              watch,
    input  logic              fbi,
    input  logic [SEL_W-1:0]  ibt,
    input  logic [NCH-1:0]    cat,
    input  logic              rpt_ready,
    output logic              rpt_valid,
    output logic [1:0]        rpt_code,
    output logic [SEL_W-1:0]  rpt_ch,
    output logic [BULL_W-1:0] bull,
    output logic [STAR_W-1:0] star,
    output logic [NCH-1:0]    pluto,
    output logic              marssr,
    output logic              lsd,
    output logic              verr_f,
    output logic              end_flag
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam logic [BULL_W:0] c_bull_match = (BULL_W+1)'(BULL_MATCH);
    localparam logic [STAR_W:0] c_star_max   = (STAR_W+1)'(STAR_MAX);
    localparam logic [SEL_W:0]  c_nch        = (SEL_W+1)'(NCH);
    localparam logic [1:0]      c_code_match = 2'b01;
    localparam logic [1:0]      c_code_limit = 2'b10;

    state_t            r_state;
    logic              r_rpt_valid;
    logic [1:0]        r_rpt_code;
    logic [SEL_W-1:0]  r_rpt_ch;
    logic [BULL_W-1:0] r_bull;
    logic [STAR_W-1:0] r_star;
    logic [NCH-1:0]    r_pluto;
    logic              r_marssr;
    logic              r_lsd;
    logic              r_verr_f;
    logic              r_end;

    logic              w_sel_ok;
    logic              w_cat_sel;
    logic              w_fault;
    logic              w_match;
    logic              w_limit;
    logic [BULL_W:0]   w_bull_nx;
    logic [STAR_W:0]   w_star_nx;
    logic [NCH-1:0]    w_pluto_set;

    // Channel qualification and event detection for the current RUN cycle
    always_comb begin
        w_sel_ok  = ({1'b0, ibt} < c_nch);
        // Out-of-range selects read as "healthy" so they can never fault
        w_cat_sel = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (ibt == SEL_W'(k)) begin
                w_cat_sel = cat[k];
            end
        end
        w_bull_nx = {1'b0, r_bull} + 1'b1;
        w_star_nx = {1'b0, r_star} + 1'b1;
        w_fault   = watch & fbi & w_sel_ok & ~w_cat_sel;
        w_match   = watch & (w_bull_nx == c_bull_match);
        w_limit   = w_fault & (w_star_nx == c_star_max);
    end

    // One-hot of the latched report channel; illegal channels map to nothing
    always_comb begin
        w_pluto_set = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_rpt_ch == SEL_W'(k)) begin
                w_pluto_set[k] = 1'b1;
            end
        end
    end

    // Controller FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rpt_valid <= 1'b0;
            r_rpt_code  <= 2'b00;
            r_rpt_ch    <= '0;
            r_bull      <= '0;
            r_star      <= '0;
            r_pluto     <= '0;
            r_marssr    <= 1'b0;
            r_lsd       <= 1'b0;
            r_verr_f    <= 1'b0;
            r_end       <= 1'b0;
        end else if (iclr) begin
            r_state     <= ST_IDLE;
            r_rpt_valid <= 1'b0;
            r_rpt_code  <= 2'b00;
            r_rpt_ch    <= '0;
            r_bull      <= '0;
            r_star      <= '0;
            r_pluto     <= '0;
            r_marssr    <= 1'b0;
            r_lsd       <= 1'b0;
            r_verr_f    <= 1'b0;
            r_end       <= 1'b0;
        end else if (r_state == ST_HALT) begin
            // Terminal until cleared: hold everything, END stays asserted
            r_end <= 1'b1;
        end else if (!owl_n) begin
            // Quiesce: drop any pending report, keep sticky flags and hit map
            r_state     <= ST_IDLE;
            r_rpt_valid <= 1'b0;
            r_rpt_code  <= 2'b00;
            r_rpt_ch    <= '0;
            r_bull      <= '0;
            r_star      <= '0;
            r_verr_f    <= 1'b0;
            r_end       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_verr_f <= 1'b0;
                    if (watch) begin
                        r_state <= ST_RUN;
                        r_bull  <= w_bull_nx[BULL_W-1:0];
                    end
                end
                ST_RUN: begin
                    r_verr_f <= watch & ~w_sel_ok;
                    if (!watch) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_bull <= w_bull_nx[BULL_W-1:0];
                        if (w_fault) begin
                            r_star <= w_star_nx[STAR_W-1:0];
                        end
                        if (w_match || w_limit) begin
                            r_state     <= ST_REPORT;
                            r_rpt_valid <= 1'b1;
                            // LIMIT dominates the code when both fire together
                            r_rpt_code  <= w_limit ? c_code_limit : c_code_match;
                            r_rpt_ch    <= ibt;
                            if (w_match) begin
                                r_marssr <= 1'b1;
                            end
                            if (w_limit) begin
                                r_lsd <= 1'b1;
                            end
                        end
                    end
                end
                ST_REPORT: begin
                    r_verr_f <= 1'b0;
                    if (rpt_ready) begin
                        r_rpt_valid <= 1'b0;
                        r_rpt_code  <= 2'b00;
                        r_pluto     <= r_pluto | w_pluto_set;
                        if (r_rpt_code == c_code_limit) begin
                            r_state <= ST_HALT;
                            r_end   <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_bull  <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign rpt_valid = r_rpt_valid;
    assign rpt_code  = r_rpt_code;
    assign rpt_ch    = r_rpt_ch;
    assign bull      = r_bull;
    assign star      = r_star;
    assign pluto     = r_pluto;
    assign marssr    = r_marssr;
    assign lsd       = r_lsd;
    assign verr_f    = r_verr_f;
    assign end_flag  = r_end;

endmodule
`default_nettype wire
